// File: rtl/nano_dmem.sv
// nano_dmem: data-memory responder for the core's load/store interface.
// Stores place bytes by lane strobe, loads extract and extend a lane, and
// every request gets exactly one in-order response after LATENCY cycles,
// queued in a small FIFO when the core stalls the response channel.
`timescale 1ns/1ps

module nano_dmem #(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);
    localparam int AW    = $clog2(WORDS);
    localparam int DEPTH = LATENCY + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [31:0]   mem [WORDS];
    logic [29:0]   word_addr;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic          req_err;
    logic          accept;
    logic          pop;
    logic [3:0]    be;
    logic [31:0]   wlane;

    logic          vld_p0;
    logic [31:0]   rdata_p0;
    logic          err_p0;
    logic          push_vld;
    logic [31:0]   push_rdata;
    logic          push_err;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   fifo_rdata [DEPTH];
    logic          fifo_err   [DEPTH];

    // Pick the addressed lane(s) out of a word and sign/zero extend them.
    function automatic logic [31:0] ext_load(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane_sel,
                                             input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane_sel, 3'b000} +: 8];
        h = lane_sel[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    r = {{24{b[7] & ~uns}}, b};
            2'd1:    r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Wrap a FIFO pointer at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign word_addr = i_req_addr[31:2];
    assign lane      = i_req_addr[1:0];
    assign idx       = word_addr[AW-1:0];

    // Faults: illegal size, misalignment, or a word index past the array.
    assign req_err = (i_req_size == 2'd3)
                  || (i_req_size == 2'd1 && i_req_addr[0])
                  || (i_req_size == 2'd2 && lane != 2'd0)
                  || ({1'b0, word_addr} >= 31'(WORDS));

    assign o_req_ready = (outstanding < DEPTH_C);
    assign accept      = i_req_valid && o_req_ready;
    assign o_rsp_valid = (fifo_cnt != '0);
    assign pop         = o_rsp_valid && i_rsp_ready;

    // Replicate store data across lanes and build the per-lane strobe.
    always_comb begin
        be    = 4'b0000;
        wlane = i_req_wdata;
        case (i_req_size)
            2'd0: begin
                be    = 4'b0001 << lane;
                wlane = {4{i_req_wdata[7:0]}};
            end
            2'd1: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{i_req_wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    // Stage p0: the accepted request's response, formed from the word as it
    // stands before this edge's store (only one request per edge anyway).
    assign vld_p0   = accept;
    assign err_p0   = req_err;
    assign rdata_p0 = (i_req_we || req_err) ? '0
                    : ext_load(mem[idx], i_req_size, lane, i_req_unsigned);

    // Commit strobed lanes of a legal store on its accept edge; never while in reset.
    always_ff @(posedge i_clk) begin
        if (accept && i_req_we && !req_err && !i_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wlane[b*8 +: 8];
            end
        end
    end

    // Latency pipe: LATENCY-1 registered stages ahead of the FIFO push, so the
    // FIFO write itself is the final stage of the delay.
    generate
        if (LATENCY == 1) begin : g_nopipe
            assign push_vld   = vld_p0;
            assign push_rdata = rdata_p0;
            assign push_err   = err_p0;
        end else begin : g_pipe
            logic        vld_pn   [LATENCY-1];
            logic [31:0] rdata_pn [LATENCY-1];
            logic        err_pn   [LATENCY-1];

            // Shift the valid bits; cleared on reset to drop in-flight work.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int s = 0; s < LATENCY-1; s++) vld_pn[s] <= 1'b0;
                end else begin
                    vld_pn[0] <= vld_p0;
                    for (int s = 1; s < LATENCY-1; s++) vld_pn[s] <= vld_pn[s-1];
                end
            end

            // Shift the response payload alongside its valid bit.
            always_ff @(posedge i_clk) begin
                rdata_pn[0] <= rdata_p0;
                err_pn[0]   <= err_p0;
                for (int s = 1; s < LATENCY-1; s++) begin
                    rdata_pn[s] <= rdata_pn[s-1];
                    err_pn[s]   <= err_pn[s-1];
                end
            end

            assign push_vld   = vld_pn[LATENCY-2];
            assign push_rdata = rdata_pn[LATENCY-2];
            assign push_err   = err_pn[LATENCY-2];
        end
    endgenerate

    // Count requests accepted but not yet handed back; gates o_req_ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outstanding <= '0;
        end else if (accept && !pop) begin
            outstanding <= outstanding + CW'(1);
        end else if (pop && !accept) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    // Response FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)      rd_ptr <= ptr_inc(rd_ptr);
            if (push_vld && !pop) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (pop && !push_vld) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end
        end
    end

    // Response FIFO storage.
    always_ff @(posedge i_clk) begin
        if (push_vld) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= push_err;
        end
    end

    // Payload is forced to zero whenever nothing is being presented.
    assign o_rsp_rdata = o_rsp_valid ? fifo_rdata[rd_ptr] : '0;
    assign o_rsp_err   = o_rsp_valid && fifo_err[rd_ptr];

endmodule

// File: tb/tb_nano_dmem.sv
// Bench for nano_dmem: randomized load/store traffic against a byte-array
// reference memory and an expected-response queue.
`timescale 1ns/1ps

module tb_nano_dmem;
    localparam int WORDS = 256;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_uns;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    rsp_t       exp_q[$];
    rsp_t       got_q[$];
    logic [7:0] mem_b [WORDS*4];
    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         stall_cnt = 0;

    nano_dmem #(.WORDS(WORDS), .LATENCY(LAT)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .i_req_size     (req_size),
        .i_req_unsigned (req_uns),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every response handshake that the coming edge will complete.
    always @(negedge clk) begin : collect
        rsp_t g;
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            g.rdata = rsp_rdata;
            g.err   = rsp_err;
            g.cyc   = cyc;
            got_q.push_back(g);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference behaviour of one accepted request, on a byte-addressed memory.
    task automatic model_accept(input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [1:0] sz,
                                input logic uns);
        rsp_t        e;
        int          nb;
        logic [31:0] v;
        logic [31:0] ones;
        logic        bad;
        nb   = 1 << sz;
        ones = '1;
        bad  = (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0)
            || (sz == 2'd2 && (addr % 4) != 0) || ((addr / 4) >= WORDS);
        e.cyc = cyc;
        e.err = bad;
        e.rdata = '0;
        if (!bad && we) begin
            for (int i = 0; i < nb; i++) mem_b[addr + i] = wd[8*i +: 8];
        end else if (!bad) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(mem_b[addr + i]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (ones << (8*nb));
            e.rdata = v;
        end
        exp_q.push_back(e);
    endtask

    // Present one request and hold it until accepted (called at posedge+1).
    task automatic send(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic uns);
        int n;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wd;   req_size = sz; req_uns = uns;
        while (1) begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            stall_cnt++;
            n++;
            if (n > 50) begin
                checks++; failures++;
                $display("FAIL send_timeout: req_ready=%b, required 1 within 50 cycles", req_ready);
                req_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        model_accept(we, addr, wd, sz, uns);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (got_q.size() < n) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: got %0d responses, required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_init_mem();
        rsp_t g, e;
        rsp_ready = 1'b1;
        for (int w = 0; w < WORDS; w++) send(1'b1, 32'(w) << 2, $urandom, 2'd2, 1'b0);
        idle();
        wait_rsp(WORDS);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g.rdata !== e.rdata || g.err !== e.err) begin
                failures++;
                $display("FAIL init_store: rdata=%h err=%b, required %h %b", g.rdata, g.err, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_store_load();
        rsp_t g, e;
        int   k;
        send(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
        send(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        idle();
        wait_rsp(2);
        k = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g.rdata !== e.rdata || g.err !== e.err || (k == 1 && g.rdata !== 32'hDEADBEEF)) begin
                failures++;
                $display("FAIL store_load rsp%0d: rdata=%h err=%b, required %h %b", k, g.rdata, g.err, e.rdata, e.err);
            end
            checks++;
            if (g.cyc !== e.cyc + LAT) begin
                failures++;
                $display("FAIL store_load_latency rsp%0d: %0d cycles, required %0d", k, g.cyc - e.cyc, LAT);
            end
            k++;
        end
    endtask

    task automatic test_subword();
        rsp_t        g, e;
        logic [31:0] lit [6];
        int          k;
        lit[0] = 32'h0; lit[1] = 32'h0; lit[2] = 32'hFFFFFF80;
        lit[3] = 32'h00000080; lit[4] = 32'hFFFF8000; lit[5] = 32'h80000000;
        send(1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
        send(1'b1, 32'h13, 32'h80, 2'd0, 1'b0);
        send(1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
        send(1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
        send(1'b0, 32'h12, 32'h0, 2'd1, 1'b0);
        send(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        idle();
        wait_rsp(6);
        k = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g.rdata !== e.rdata || g.err !== e.err || (k < 6 && g.rdata !== lit[k])) begin
                failures++;
                $display("FAIL subword rsp%0d: rdata=%h err=%b, required %h %b", k, g.rdata, g.err, e.rdata, e.err);
            end
            k++;
        end
    endtask

    task automatic test_errors();
        rsp_t g, e;
        int   k;
        send(1'b1, 32'h21, 32'h1111_1111, 2'd1, 1'b0);
        send(1'b1, 32'h22, 32'h2222_2222, 2'd2, 1'b0);
        send(1'b1, 32'h24, 32'h3333_3333, 2'd3, 1'b0);
        send(1'b1, 32'(WORDS * 4), 32'h4444_4444, 2'd2, 1'b0);
        send(1'b0, 32'h21, 32'h0, 2'd1, 1'b0);
        send(1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        send(1'b0, 32'h24, 32'h0, 2'd2, 1'b0);
        send(1'b0, 32'h00, 32'h0, 2'd2, 1'b0);
        idle();
        wait_rsp(8);
        k = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g.rdata !== e.rdata || g.err !== e.err
                || (k < 5 && (g.err !== 1'b1 || g.rdata !== 32'h0))) begin
                failures++;
                $display("FAIL errors rsp%0d: rdata=%h err=%b, required %h %b", k, g.rdata, g.err, e.rdata, e.err);
            end
            k++;
        end
    endtask

    task automatic test_backpressure();
        rsp_t        g, e;
        logic [31:0] a;
        logic        took;
        int          acc;
        rsp_ready = 1'b0;
        acc = 0;
        a = 32'($urandom_range(0, WORDS-1)) << 2;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0;
        req_size = 2'd2; req_uns = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            took = (req_ready === 1'b1);
            if (took) begin
                model_accept(1'b0, a, 32'h0, 2'd2, 1'b0);
                acc++;
            end
            @(posedge clk); #1;
            if (took) begin
                a = 32'($urandom_range(0, WORDS-1)) << 2;
                req_addr = a;
            end
        end
        checks++;
        if (acc != LAT + 1) begin
            failures++;
            $display("FAIL bp_accepted: %0d accepted, required %0d", acc, LAT + 1);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_low: req_ready=%b, required 0", req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0 || rsp_valid !== 1'b1 || rsp_rdata !== exp_q[0].rdata) begin
                failures++;
                $display("FAIL bp_stable cycle%0d: valid=%b rdata=%h, required head held", c, rsp_valid, rsp_rdata);
            end
            @(posedge clk); #1;
        end
        idle();
        rsp_ready = 1'b1;
        wait_rsp(LAT + 1);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g.rdata !== e.rdata || g.err !== e.err) begin
                failures++;
                $display("FAIL bp_drain: rdata=%h err=%b, required %h %b", g.rdata, g.err, e.rdata, e.err);
            end
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_back: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_streaming();
        rsp_t        g, e;
        logic [1:0]  sz;
        logic [31:0] a;
        int          stall0, prev;
        rsp_ready = 1'b1;
        stall0 = stall_cnt;
        for (int i = 0; i < 100; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63)) & ~((32'd1 << sz) - 32'd1);
            send((i % 2) == 0, a, $urandom, sz, 1'($urandom_range(0, 1)));
        end
        idle();
        wait_rsp(100);
        checks++;
        if (stall_cnt != stall0) begin
            failures++;
            $display("FAIL stream_ready: %0d stall cycles, required 0", stall_cnt - stall0);
        end
        prev = -1;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g.rdata !== e.rdata || g.err !== e.err || g.cyc !== e.cyc + LAT
                || (prev >= 0 && g.cyc !== prev + 1)) begin
                failures++;
                $display("FAIL stream: rdata=%h err=%b cyc=%0d, required %h %b cyc=%0d",
                         g.rdata, g.err, g.cyc, e.rdata, e.err, e.cyc + LAT);
            end
            prev = g.cyc;
        end
    endtask

    task automatic test_reset_midstream();
        rsp_t g, e;
        rsp_ready = 1'b0;
        send(1'b1, 32'h40, $urandom, 2'd2, 1'b0);
        send(1'b1, 32'h45, $urandom, 2'd0, 1'b0);
        idle();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0 + (LAT + 1 > 2)) begin
            failures++;
            $display("FAIL mid_queued: valid=%b ready=%b, required 1 1", rsp_valid, req_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b ready=%b rdata=%h err=%b, required 0 1 0 0",
                     rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
        exp_q.delete();
        got_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        send(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        send(1'b0, 32'h44, 32'h0, 2'd2, 1'b0);
        idle();
        wait_rsp(2);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (g.rdata !== e.rdata || g.err !== e.err) begin
                failures++;
                $display("FAIL mid_persist: rdata=%h err=%b, required %h %b", g.rdata, g.err, e.rdata, e.err);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_uns = 1'b0; rsp_ready = 1'b1;
        test_reset();
        test_init_mem();
        test_store_load();
        test_subword();
        test_errors();
        test_backpressure();
        test_streaming();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
